// File: rtl/lc3_wb_regfile.sv
// LC-3 write-back stage register file with multi-port combinational reads.
// Define LC3_WB_BYPASS_EN to forward same-cycle write data to read ports.
module lc3_wb_regfile #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8,
  parameter int RD_PORTS = 2,
  localparam int AW      = $clog2(NUM_REGS)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       enable_writeback,
  input  logic [1:0]                 W_Control,
  input  logic [DATA_W-1:0]          aluout,
  input  logic [DATA_W-1:0]          memout,
  input  logic [DATA_W-1:0]          pcout,
  input  logic [AW-1:0]              dr,
  input  logic [RD_PORTS*AW-1:0]     sr,
  output logic [RD_PORTS*DATA_W-1:0] VSR,
  output logic [2:0]                 psr,
  output logic [15:0]                wb_count,
  output logic                       sel_err
);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [DATA_W-1:0] wdata;
  logic [2:0]        psr_next;
  logic              commit;
  logic              bad_sel;

  assign bad_sel = enable_writeback && (W_Control == 2'd3);
  assign commit  = enable_writeback && (W_Control != 2'd3);

  // Write-data source select; code 3 is illegal and never commits.
  always_comb begin
    wdata = '0;
    unique case (W_Control)
      2'd0: wdata = aluout;
      2'd1: wdata = memout;
      2'd2: wdata = pcout;
      2'd3: wdata = '0;
    endcase
  end

  // Condition codes come only from the value being written.
  always_comb begin
    psr_next = 3'b001;
    if (wdata[DATA_W-1])
      psr_next = 3'b100;
    else if (wdata == '0)
      psr_next = 3'b010;
  end

  // Register array, flags and write counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      regs     <= '{default: '0};
      psr      <= 3'b000;
      wb_count <= 16'h0000;
      sel_err  <= 1'b0;
    end else begin
      if (commit) begin
        regs[dr] <= wdata;
        psr      <= psr_next;
        wb_count <= wb_count + 16'h0001;
      end
      if (bad_sel)
        sel_err <= 1'b1;
    end
  end

  for (genvar k = 0; k < RD_PORTS; k++) begin : g_rd
    logic [AW-1:0] idx;
    assign idx = sr[k*AW +: AW];
`ifdef LC3_WB_BYPASS_EN
    assign VSR[k*DATA_W +: DATA_W] =
      (commit && idx == dr) ? wdata : regs[idx];
`else
    assign VSR[k*DATA_W +: DATA_W] = regs[idx];
`endif
  end

endmodule

// File: tb/tb_lc3_wb_regfile.sv
// Self-checking bench for lc3_wb_regfile: vector table, corner
// sequences, randomized run against a reference model, wide build.
module tb_lc3_wb_regfile;

  logic        clock;
  logic        reset;
  logic        en;
  logic [1:0]  wc;
  logic [15:0] alu, mem, pc;
  logic [2:0]  dr;
  logic [5:0]  sr;
  logic [31:0] vsr;
  logic [2:0]  psr;
  logic [15:0] cnt;
  logic        sel;

  logic         b_reset;
  logic         b_en;
  logic [1:0]   b_wc;
  logic [31:0]  b_alu, b_mem, b_pc;
  logic [3:0]   b_dr;
  logic [15:0]  b_sr;
  logic [127:0] b_vsr;
  logic [2:0]   b_psr;
  logic [15:0]  b_cnt;
  logic         b_sel;

  int total = 0;
  int bad   = 0;

  lc3_wb_regfile dut (
    .clock(clock), .reset(reset), .enable_writeback(en),
    .W_Control(wc), .aluout(alu), .memout(mem), .pcout(pc),
    .dr(dr), .sr(sr), .VSR(vsr), .psr(psr),
    .wb_count(cnt), .sel_err(sel)
  );

  lc3_wb_regfile #(.DATA_W(32), .NUM_REGS(16), .RD_PORTS(4)) u_big (
    .clock(clock), .reset(b_reset), .enable_writeback(b_en),
    .W_Control(b_wc), .aluout(b_alu), .memout(b_mem), .pcout(b_pc),
    .dr(b_dr), .sr(b_sr), .VSR(b_vsr), .psr(b_psr),
    .wb_count(b_cnt), .sel_err(b_sel)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  typedef struct {
    logic        en;
    logic [1:0]  wc;
    logic [15:0] alu, mem, pc;
    logic [2:0]  dr, s0, s1;
    logic [15:0] e0, e1;
    logic [2:0]  epsr;
    logic [15:0] ecnt;
  } vec_t;

  vec_t tbl [5];

  logic [15:0] m_reg [8];
  logic [2:0]  m_psr;
  logic [15:0] m_cnt;
  logic        m_sel;

  function automatic logic [2:0] cc(input logic [15:0] v);
    if (v >= 16'h8000) return 3'b100;
    if (v == 16'h0000) return 3'b010;
    return 3'b001;
  endfunction

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 3))
      0: return 16'h0000;
      1: return 16'h8000 | 16'($urandom);
      default: return 16'($urandom);
    endcase
  endfunction

  function automatic logic [15:0] m_read(input logic [2:0] s);
    logic [15:0] d;
    d = m_reg[s];
`ifdef LC3_WB_BYPASS_EN
    if (en && wc != 2'd3 && s == dr)
      d = (wc == 2'd0) ? alu : (wc == 2'd1) ? mem : pc;
`endif
    return d;
  endfunction

  logic [15:0] exp_by;

  initial begin
    tbl[0] = '{1'b1, 2'd0, 16'h8001, 16'h0, 16'h0, 3'd3, 3'd3, 3'd0,
               16'h8001, 16'h0000, 3'b100, 16'd1};
    tbl[1] = '{1'b1, 2'd1, 16'h0, 16'h0000, 16'h0, 3'd5, 3'd5, 3'd3,
               16'h0000, 16'h8001, 3'b010, 16'd2};
    tbl[2] = '{1'b1, 2'd2, 16'h0, 16'h0, 16'h3001, 3'd7, 3'd7, 3'd7,
               16'h3001, 16'h3001, 3'b001, 16'd3};
    tbl[3] = '{1'b0, 2'd0, 16'hFFFF, 16'h0, 16'h0, 3'd3, 3'd3, 3'd7,
               16'h8001, 16'h3001, 3'b001, 16'd3};
    tbl[4] = '{1'b1, 2'd0, 16'h7FFF, 16'h0, 16'h0, 3'd1, 3'd1, 3'd5,
               16'h7FFF, 16'h0000, 3'b001, 16'd4};

    reset = 1'b1; en = 0; wc = 0; alu = 0; mem = 0; pc = 0;
    dr = 0; sr = 0;
    b_reset = 1'b1; b_en = 0; b_wc = 0; b_alu = 0; b_mem = 0;
    b_pc = 0; b_dr = 0; b_sr = 0;
    tick(); tick();
    chk("rst_psr", 64'(psr), 64'(3'b000));
    chk("rst_cnt", 64'(cnt), 64'd0);
    chk("rst_sel", 64'(sel), 64'd0);
    chk("rst_vsr", 64'(vsr), 64'd0);
    reset = 1'b0;
    b_reset = 1'b0;

    for (int i = 0; i < 5; i++) begin
      en = tbl[i].en; wc = tbl[i].wc; alu = tbl[i].alu;
      mem = tbl[i].mem; pc = tbl[i].pc; dr = tbl[i].dr;
      sr = {tbl[i].s1, tbl[i].s0};
      tick();
      chk($sformatf("tbl%0d_p0", i), 64'(vsr[15:0]), 64'(tbl[i].e0));
      chk($sformatf("tbl%0d_p1", i), 64'(vsr[31:16]), 64'(tbl[i].e1));
      chk($sformatf("tbl%0d_psr", i), 64'(psr), 64'(tbl[i].epsr));
      chk($sformatf("tbl%0d_cnt", i), 64'(cnt), 64'(tbl[i].ecnt));
      chk($sformatf("tbl%0d_sel", i), 64'(sel), 64'd0);
    end

    en = 1; wc = 2'd3; alu = 16'h5555; mem = 16'h5555; pc = 16'h5555;
    dr = 3'd2; sr = {3'd2, 3'd2};
    tick();
    chk("ill_reg2", 64'(vsr[15:0]), 64'h0);
    chk("ill_psr", 64'(psr), 64'(3'b001));
    chk("ill_cnt", 64'(cnt), 64'd4);
    chk("ill_sel", 64'(sel), 64'd1);
    wc = 2'd0; alu = 16'h0000; dr = 3'd6; sr = {3'd6, 3'd6};
    tick();
    chk("ill_sticky", 64'(sel), 64'd1);
    chk("ill_after_psr", 64'(psr), 64'(3'b010));
    chk("ill_after_cnt", 64'(cnt), 64'd5);
    en = 0;
    tick();
    chk("ill_hold", 64'(sel), 64'd1);

    en = 1; wc = 2'd0; alu = 16'h1234; dr = 3'd4; sr = {3'd4, 3'd3};
    #1;
`ifdef LC3_WB_BYPASS_EN
    exp_by = 16'h1234;
`else
    exp_by = 16'h0000;
`endif
    chk("byp_same_cycle", 64'(vsr[31:16]), 64'(exp_by));
    chk("byp_other_port", 64'(vsr[15:0]), 64'h8001);
    tick();
    en = 0;
    #1;
    chk("byp_next_cycle", 64'(vsr[31:16]), 64'h1234);

    reset = 1'b1;
    #2;
    reset = 1'b0;
    for (int i = 0; i < 8; i++) m_reg[i] = '0;
    m_psr = 3'b000; m_cnt = 16'h0; m_sel = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clock);
      en  = ($urandom_range(0, 3) != 0);
      wc  = 2'($urandom_range(0, 3));
      alu = pick(); mem = pick(); pc = pick();
      dr  = 3'($urandom);
      sr  = 6'($urandom);
      #1;
      chk("rnd_p0", 64'(vsr[15:0]), 64'(m_read(sr[2:0])));
      chk("rnd_p1", 64'(vsr[31:16]), 64'(m_read(sr[5:3])));
      @(posedge clock);
      if (en && wc == 2'd3) m_sel = 1'b1;
      if (en && wc != 2'd3) begin
        exp_by = (wc == 2'd0) ? alu : (wc == 2'd1) ? mem : pc;
        m_reg[dr] = exp_by;
        m_psr = cc(exp_by);
        m_cnt = m_cnt + 16'd1;
      end
      #1;
      chk("rnd_psr", 64'(psr), 64'(m_psr));
      chk("rnd_cnt", 64'(cnt), 64'(m_cnt));
      chk("rnd_sel", 64'(sel), 64'(m_sel));
    end
    en = 0;

    b_en = 1; b_wc = 2'd0; b_alu = 32'hDEADBEEF; b_dr = 4'd9;
    b_sr = {4{4'd9}};
    tick();
    b_en = 0;
    #1;
    for (int k = 0; k < 4; k++)
      chk($sformatf("big_p%0d", k), 64'(b_vsr[k*32 +: 32]),
          64'hDEADBEEF);
    chk("big_psr", 64'(b_psr), 64'(3'b100));
    chk("big_cnt", 64'(b_cnt), 64'd1);

    reset = 1'b1;
    tick();
    reset = 1'b0;
    en = 1; wc = 2'd0; alu = 16'h0001; dr = 3'd0; sr = 6'd0;
    repeat (65535) @(posedge clock);
    #1;
    chk("wrap_ffff", 64'(cnt), 64'hFFFF);
    tick();
    chk("wrap_zero", 64'(cnt), 64'h0000);
    wc = 2'd3;
    tick();
    en = 0;
    chk("pre_rst_sel", 64'(sel), 64'd1);
    chk("pre_rst_reg0", 64'(vsr[15:0]), 64'h0001);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_vsr", 64'(vsr), 64'd0);
    chk("mid_rst_psr", 64'(psr), 64'd0);
    chk("mid_rst_cnt", 64'(cnt), 64'd0);
    chk("mid_rst_sel", 64'(sel), 64'd0);
    en = 1; wc = 2'd0; alu = 16'h0005;
    tick();
    chk("rst_discard_cnt", 64'(cnt), 64'd0);
    chk("rst_discard_reg", 64'(vsr[15:0]), 64'h0);
    reset = 1'b0;
    tick();
    en = 0;
    chk("post_rst_cnt", 64'(cnt), 64'd1);
    chk("post_rst_reg", 64'(vsr[15:0]), 64'h0005);
    chk("post_rst_psr", 64'(psr), 64'(3'b001));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
